// File: rtl/vadder_sched_pkg.sv
// Shared types and constants for the two-requester serial wide adder.
package vadder_sched_pkg;

    localparam int NREQ = 2;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

endpackage

// File: rtl/vadder_sched_if.sv
// Request/response bundle for vadder_sched: two requesters in, one response out.
interface vadder_sched_if
    import vadder_sched_pkg::*;
#(
    parameter int nbits  = 32,
    parameter int nwords = 4
);

    localparam int W = nbits * nwords;

    logic [NREQ-1:0]         req_val;
    logic [NREQ-1:0]         req_rdy;
    logic [NREQ-1:0][W-1:0]  req_in0;
    logic [NREQ-1:0][W-1:0]  req_in1;
    logic [NREQ-1:0]         req_cin;
    logic                    resp_val;
    logic                    resp_rdy;
    logic [W-1:0]            resp_out;
    logic                    resp_cout;
    logic                    resp_id;

    modport master (
        output req_val, req_in0, req_in1, req_cin, resp_rdy,
        input  req_rdy, resp_val, resp_out, resp_cout, resp_id
    );

    modport slave (
        input  req_val, req_in0, req_in1, req_cin, resp_rdy,
        output req_rdy, resp_val, resp_out, resp_cout, resp_id
    );

endinterface

// File: rtl/VAdder.sv
// Single nbits-wide adder word with carry-in and carry-out.
module VAdder #(
    parameter int nbits = 32
) (
    input  logic [nbits-1:0] in0,
    input  logic [nbits-1:0] in1,
    input  logic             cin,
    output logic [nbits-1:0] out,
    output logic             cout
);

    assign {cout, out} = {1'b0, in0} + {1'b0, in1} + {{nbits{1'b0}}, cin};

endmodule

// File: rtl/vadder_sched.sv
// Round-robin scheduler sharing one word adder between two requesters;
// each W-bit add runs serially, least-significant word first.
module vadder_sched
    import vadder_sched_pkg::*;
#(
    parameter int nbits  = 32,
    parameter int nwords = 4
) (
    input  logic           clk,
    input  logic           reset,
    vadder_sched_if.slave  bus
);

    localparam int W  = nbits * nwords;
    localparam int CW = (nwords > 1) ? $clog2(nwords) : 1;
    localparam logic [CW-1:0] LAST = CW'(nwords - 1);

    state_t          state;
    logic            ptr;
    logic [CW-1:0]   cnt;
    logic            carry;
    logic            id_q;
    logic            resp_val_q;
    logic [W-1:0]    sum_q;

    logic [W-1:0]    a_q;
    logic [W-1:0]    b_q;
    logic            cin_q;

    logic            any_val;
    logic            winner;
    logic [NREQ-1:0] grant;

    logic [nbits-1:0] word_a;
    logic [nbits-1:0] word_b;
    logic [nbits-1:0] word_s;
    logic             word_ci;
    logic             word_co;

    // Pointer holder wins if valid, otherwise the other requester.
    always_comb begin
        any_val = |bus.req_val;
        winner  = bus.req_val[ptr] ? ptr : ~ptr;
        grant   = '0;
        if (state == IDLE && any_val) begin
            grant[winner] = 1'b1;
        end
    end

    assign bus.req_rdy   = grant;
    assign bus.resp_val  = resp_val_q;
    assign bus.resp_out  = sum_q;
    assign bus.resp_cout = carry;
    assign bus.resp_id   = id_q;

    assign word_a  = a_q[int'(cnt) * nbits +: nbits];
    assign word_b  = b_q[int'(cnt) * nbits +: nbits];
    assign word_ci = (cnt == '0) ? cin_q : carry;

    VAdder #(.nbits(nbits)) u_add (
        .in0  (word_a),
        .in1  (word_b),
        .cin  (word_ci),
        .out  (word_s),
        .cout (word_co)
    );

    // Operand capture: only meaningful after a handshake, so no reset needed.
    always_ff @(posedge clk) begin
        if (state == IDLE && any_val) begin
            a_q   <= bus.req_in0[winner];
            b_q   <= bus.req_in1[winner];
            cin_q <= bus.req_cin[winner];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            ptr        <= 1'b0;
            cnt        <= '0;
            carry      <= 1'b0;
            sum_q      <= '0;
            id_q       <= 1'b0;
            resp_val_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_val) begin
                        id_q  <= winner;
                        ptr   <= ~winner;
                        cnt   <= '0;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    sum_q[int'(cnt) * nbits +: nbits] <= word_s;
                    carry <= word_co;
                    if (cnt == LAST) begin
                        state      <= DONE;
                        resp_val_q <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    // No request is granted in the cycle the response drains.
                    if (bus.resp_rdy) begin
                        state      <= IDLE;
                        resp_val_q <= 1'b0;
                    end
                end
                default: begin
                    state      <= IDLE;
                    resp_val_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/vadder_sched.md
VADDER_SCHED -- requirements
Module: vadder_sched

Interface
REQ-001 Parameter nbits, default 32, width of one adder word.
REQ-002 Parameter nwords, default 4, words per request (>=1); operand width W = nbits*nwords.
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 req_val  input  2  per-requester request valid.
REQ-006 req_rdy  output  2  per-requester request ready (grant).
REQ-007 req_in0  input  2xW  per-requester operand A.
REQ-008 req_in1  input  2xW  per-requester operand B.
REQ-009 req_cin  input  2  per-requester carry-in.
REQ-010 resp_val  output  1  response valid.
REQ-011 resp_rdy  input  1  response ready.
REQ-012 resp_out  output  W  sum modulo 2^W.
REQ-013 resp_cout  output  1  carry out of bit W-1.
REQ-014 resp_id  output  1  index of the requester that issued the response.

Function
REQ-015 Block SHALL share one nbits carry-in word adder between two requesters, executing each W-bit add serially, least-significant word first, one word per cycle.
REQ-016 FSM states SHALL be IDLE, BUSY, DONE.
REQ-017 IDLE: req_rdy SHALL be one-hot on the granted requester when any req_val is set, else 0; req_rdy SHALL be 0 in BUSY and DONE.
REQ-018 Grant SHALL be round-robin: requester at priority pointer wins if valid, else the other; pointer SHALL move to the non-winner after each accepted request.
REQ-019 On handshake (req_val&req_rdy) SHALL latch both operands, cin and id, clear word counter, enter BUSY.
REQ-020 BUSY cycle k (k=0..nwords-1) SHALL add word k of A and B with carry = latched cin for k=0, else registered carry of word k-1, and register result word k and its carry.
REQ-021 After BUSY cycle nwords-1, SHALL enter DONE; resp_val SHALL be 1 exactly in DONE.
REQ-022 Latency: handshake in cycle 0 -> resp_val first high in cycle nwords+1.
REQ-023 resp_out, resp_cout, resp_id SHALL stay stable while resp_val=1 and resp_rdy=0.
REQ-024 DONE with resp_rdy=1 SHALL return to IDLE; no new request accepted in the same cycle (peak throughput one request per nwords+2 cycles).
REQ-025 Request inputs SHALL be ignored outside the IDLE handshake; operand changes after handshake do not affect the result.
REQ-026 Wrap-around: carry out of the top word SHALL drive resp_cout; sum discards it (mod 2^W).
REQ-027 nwords=1 SHALL behave identically with one BUSY cycle.

Reset
REQ-028 Reset SHALL force state IDLE, pointer to requester 0, counter 0, carry 0, result 0, resp_id 0, resp_val 0.
REQ-029 Reset asserted in BUSY or DONE SHALL abort the operation with no response; first post-reset request re-arbitrated from pointer 0.

Structure
REQ-030 Package vadder_sched_pkg SHALL hold the state enum and NREQ=2 constant.
REQ-031 Sole sub-module SHALL be the nbits carry-in word adder VAdder (parameter nbits), instantiated once; all sequencing in vadder_sched.

Verification (nbits=32, nwords=4)
REQ-032 Req0 A=0x0000_0000_0000_0000_0000_0000_FFFF_FFFF, B=1, cin=0 -> resp_out=0x1_0000_0000, cout=0, id=0, resp_val in cycle 5.
REQ-033 Req1 A=all-ones(128), B=0, cin=1 -> resp_out=0, cout=1, id=1 (carry ripples through all 4 words).
REQ-034 Both req_val held high from reset, 4 requests, resp_rdy=1 -> ids 0,1,0,1; each accepted 6 cycles apart.
REQ-035 resp_rdy=0 for 10 cycles in DONE -> resp_val, resp_out, resp_id constant, req_rdy=00; resp_rdy=1 -> IDLE next cycle.
REQ-036 Reset pulsed in BUSY cycle 2 -> resp_val never asserted for that request; next req1-only request granted normally, id=1.
